// File: rtl/bcd_conv_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_conv_arbiter_pkg
//  Description : Shared types and constants for the arbitrated, iterative
//                binary-to-BCD converter. It holds the FSM state encoding,
//                the default sizes and the double-dabble adjust constants.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package bcd_conv_arbiter_pkg;

   // Controller states
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CONV = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Default sizing: 8-bit binary input gives three BCD digits (max 255)
   localparam int DEF_W      = 8;
   localparam int DEF_DIGITS = 3;

   // Double-dabble correction: a digit above 4 gets 3 added before the shift
   localparam logic [3:0] c_ADJ_THRESH = 4'd4;
   localparam logic [3:0] c_ADJ_OFFSET = 4'd3;

endpackage : bcd_conv_arbiter_pkg
`default_nettype wire

// File: rtl/bcd_conv_arbiter_dabble_step.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_dabble_step
//  Description : One combinational double-dabble iteration. Every BCD digit
//                nibble above the binary field is corrected (+3 when > 4,
//                4-bit add without carry-out), then the whole vector is
//                shifted left by one with a zero fill.
//  Ports       : i_sr [4*DIGITS+W-1:0]  current shift register contents
//                o_sr [4*DIGITS+W-1:0]  adjusted and shifted value
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_dabble_step
   import bcd_conv_arbiter_pkg::*;
#(
   parameter int DIGITS = DEF_DIGITS,
   parameter int W      = DEF_W
) (
   input  logic [4*DIGITS+W-1:0] i_sr,
   output logic [4*DIGITS+W-1:0] o_sr
);

   logic [4*DIGITS+W-1:0] w_adj;

   // The binary field below the digits passes through untouched
   assign w_adj[W-1:0] = i_sr[W-1:0];

   generate
      for (genvar d = 0; d < DIGITS; d++) begin : g_digit
         logic [3:0] w_nib;
         assign w_nib                = i_sr[W+4*d +: 4];
         assign w_adj[W+4*d +: 4]    = (w_nib > c_ADJ_THRESH) ? (w_nib + c_ADJ_OFFSET) : w_nib;
      end
   endgenerate

   // Top bit of the adjusted vector is always zero for legal inputs and is
   // dropped by the shift.
   assign o_sr = w_adj << 1;

endmodule : bcd_dabble_step
`default_nettype wire

// File: rtl/bcd_conv_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_conv_arbiter
//  Description : Round-robin arbiter in front of a shared, iterative
//                double-dabble binary-to-BCD engine. A granted value is
//                converted in W cycles and presented with valid/ready.
//  Ports       : clk        clock, rising edge
//                rst        asynchronous active-high reset
//                req_valid  [NREQ]      per-requester request
//                req_data   [NREQ*W]    requester i at [i*W +: W]
//                req_ready  [NREQ]      one-hot accept strobe (combinational)
//                out_valid              result available
//                out_ready              consumer accepts result
//                out_id     [2]         requester index of the result
//                out_bcd    [4*DIGITS]  BCD result, [3:0] is the ones digit
//                busy                   high while converting or holding
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_conv_arbiter
   import bcd_conv_arbiter_pkg::*;
#(
   parameter int NREQ   = 3,
   parameter int W      = DEF_W,
   parameter int DIGITS = DEF_DIGITS
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*W-1:0]     req_data,
   output logic [NREQ-1:0]       req_ready,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [1:0]            out_id,
   output logic [4*DIGITS-1:0]   out_bcd,
   output logic                  busy
);

   localparam int SRW = 4*DIGITS + W;
   localparam int CW  = $clog2(W) + 1;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [SRW-1:0]      r_sr;
   logic [SRW-1:0]      w_sr_nxt;
   logic [SRW-1:0]      w_sr_step;
   logic [CW-1:0]       r_cnt;
   logic [CW-1:0]       w_cnt_nxt;
   logic [1:0]          r_rr_ptr;
   logic [1:0]          w_rr_nxt;
   logic [1:0]          r_id;
   logic [1:0]          w_id_nxt;

   // Arbitration signals
   logic [2*NREQ-1:0]   w_rv_rot;
   logic [1:0]          w_off;
   logic [2:0]          w_sum;
   logic [1:0]          w_grant;
   logic                w_any;
   logic [W-1:0]        w_grant_data;

   // ------------------------------------------------------------------------
   // Round-robin search: rotate the request vector so that rr_ptr lands on
   // bit 0, pick the lowest set bit, then map the offset back to an index.
   // ------------------------------------------------------------------------
   assign w_rv_rot = {req_valid, req_valid} >> r_rr_ptr;
   assign w_any    = |req_valid;

   always_comb begin
      w_off = 2'd0;
      for (int j = NREQ-1; j >= 0; j--) begin
         if (w_rv_rot[j]) begin
            w_off = 2'(j);
         end
      end
   end

   assign w_sum        = {1'b0, r_rr_ptr} + {1'b0, w_off};
   assign w_grant      = (w_sum >= 3'(NREQ)) ? 2'(w_sum - 3'(NREQ)) : w_sum[1:0];
   assign w_grant_data = req_data[int'(w_grant)*W +: W];

   always_comb begin
      req_ready = '0;
      if ((r_state == S_IDLE) && w_any) begin
         req_ready = NREQ'(1) << w_grant;
      end
   end

   // ------------------------------------------------------------------------
   // Shared conversion step
   // ------------------------------------------------------------------------
   bcd_dabble_step #(
      .DIGITS (DIGITS),
      .W      (W)
   ) u_step (
      .i_sr   (r_sr),
      .o_sr   (w_sr_step)
   );

   // ------------------------------------------------------------------------
   // FSM next-state and datapath next values
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_sr_nxt    = r_sr;
      w_cnt_nxt   = r_cnt;
      w_rr_nxt    = r_rr_ptr;
      w_id_nxt    = r_id;
      case (r_state)
         S_IDLE: begin
            if (w_any) begin
               w_sr_nxt    = {{(4*DIGITS){1'b0}}, w_grant_data};
               w_id_nxt    = w_grant;
               w_cnt_nxt   = '0;
               w_rr_nxt    = (w_grant == 2'(NREQ-1)) ? 2'd0 : (w_grant + 2'd1);
               w_state_nxt = S_CONV;
            end
         end
         S_CONV: begin
            w_sr_nxt  = w_sr_step;
            w_cnt_nxt = r_cnt + CW'(1);
            if (r_cnt == CW'(W-1)) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_sr     <= '0;
         r_cnt    <= '0;
         r_rr_ptr <= 2'd0;
         r_id     <= 2'd0;
      end else begin
         r_state  <= w_state_nxt;
         r_sr     <= w_sr_nxt;
         r_cnt    <= w_cnt_nxt;
         r_rr_ptr <= w_rr_nxt;
         r_id     <= w_id_nxt;
      end
   end

   // Outputs decode directly from registered state; the BCD field of the
   // shift register is frozen in DONE, so out_bcd holds under backpressure.
   assign out_valid = (r_state == S_DONE);
   assign out_bcd   = r_sr[SRW-1:W];
   assign out_id    = r_id;
   assign busy      = (r_state != S_IDLE);

endmodule : bcd_conv_arbiter
`default_nettype wire
